instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction memory: the IF stage reads instructions, this block fills the memory before execution.
- Assembles a byte stream (from the UART receiver) into 32-bit instruction words and issues one write per word at sequential byte addresses (0, 4, 8, …).
- Holds the PC and fetch path in reset until loading ends, then releases them.
- Loading ends on a HALT word or when the memory is full.

Parameters:
- NB_PC, 32, address width; matches the PC width.
- NB_INSTRUCTION, 32, instruction word width.
- NB_BYTE, 8, width of the input byte stream.
- MEM_DEPTH, 64, instruction memory capacity in words.
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is written to memory.

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse that starts a load; honoured only in IDLE or DONE.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_done  in  1  single-cycle strobe marking i_rx_data valid.
- o_wr_enable  out  1  instruction memory write strobe.
- o_wr_addr  out  NB_PC  byte address of the write.
- o_wr_data  out  NB_INSTRUCTION  word being written.
- o_pc_hold  out  1  high keeps the PC and fetch in reset.
- o_load_done  out  1  high in DONE.
- o_error  out  1  sticky error flag; cleared by reset or by i_start.
- o_word_count  out  NB_PC  number of words written in the current load.
- o_checksum  out  NB_BYTE  running checksum (see Optional Feature).

Behaviour:
- Reset values (asynchronous assertion, synchronous release):
  - state = IDLE.
  - o_wr_enable = 0, o_wr_addr = 0, o_wr_data = 0.
  - o_pc_hold = 1, o_load_done = 0, o_error = 0.
  - o_word_count = 0, o_checksum = 0.
  - Byte index = 0; any partial word is discarded.
- IDLE:
  - i_rx_done is ignored.
  - i_start clears the address, word count, error, checksum and byte index, then goes to RECV.
- RECV:
  - Each i_rx_done captures i_rx_data into the word buffer. Byte order is big-endian: the first byte goes to [31:24], the fourth to [7:0].
  - On the fourth byte, go to WRITE.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_wr_enable = 1, o_wr_addr = word_index*4, o_wr_data = assembled word.
  - Latency: the write appears one cycle after the i_rx_done of the fourth byte.
  - o_word_count increments in this cycle (its registered value updates on the next edge).
  - An i_rx_done arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
  - Next state:
    - Word equals HALT_WORD: go to DONE (or CHECK when the option is enabled).
    - Otherwise, word_index == MEM_DEPTH-1: go to DONE with o_error = 1 (overflow; memory full without HALT).
    - Otherwise: increment the address by 4 and go to RECV.
- DONE:
  - o_load_done = 1.
  - o_pc_hold = 0 only if o_error = 0; on error, hold stays high.
  - i_rx_done is ignored.
  - i_start restarts the load as from IDLE, with the address back to 0.
- o_pc_hold is 1 in IDLE, RECV, WRITE and CHECK.
- o_wr_enable is never asserted outside WRITE.
- Reset asserted mid-operation aborts immediately. No write is issued for a partial word.
- i_start coinciding with i_rx_done in IDLE or DONE: the start is taken and the byte is dropped.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Enabled:
  - o_checksum = XOR of every received instruction byte, including the HALT bytes.
  - After the HALT write, the FSM enters CHECK and waits for one more byte.
  - Byte equals o_checksum: go to DONE with o_error = 0.
  - Byte differs: go to DONE with o_error = 1 and o_pc_hold stays 1.
- Disabled:
  - o_checksum is tied to 0.
  - The CHECK state does not exist; HALT goes straight to DONE.

Test Plan:
1. Reset, i_start, then bytes 20 08 00 05, FF FF FF FF:
   - Write addr 0x0 data 0x20080005, then addr 0x4 data 0xFFFFFFFF.
   - o_word_count = 2, o_load_done = 1, o_pc_hold = 0, o_error = 0.
2. Next word's first byte strobed in the WRITE cycle (i_rx_done on consecutive cycles):
   - Stream 00 00 00 01 | 00 00 00 02 | FF×4 gives data 0x00000001, 0x00000002 and HALT at addresses 0, 4, 8.
3. MEM_DEPTH=4, four non-HALT words:
   - Writes at 0, 4, 8, 12.
   - DONE with o_error = 1, o_pc_hold = 1.
4. Reset pulsed low after 2 bytes of a word:
   - All outputs return to reset values.
   - After i_start plus a full word 8C 01 00 00, the write goes to addr 0 data 0x8C010000.
5. Bytes before i_start and after DONE produce no o_wr_enable.
6. With INSTR_LOADER_CHECKSUM_EN, words 0x12345678 and HALT:
   - Checksum byte 0x08 gives DONE with o_error = 0.
   - Checksum byte 0x09 gives o_error = 1 and o_pc_hold = 1.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: packs a received byte stream into instruction words and writes
// them to instruction memory at byte addresses 0, 4, 8, ...
// The PC and the fetch path stay in reset until loading ends.
// Loading ends on a HALT word or when the memory is full.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN. When it is defined, a trailing
// XOR checksum byte is checked after the HALT word.
module instruction_loader #(
    parameter int unsigned               NB_PC          = 32,
    parameter int unsigned               NB_INSTRUCTION = 32,
    parameter int unsigned               NB_BYTE        = 8,
    parameter int unsigned               MEM_DEPTH      = 64,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = {NB_INSTRUCTION{1'b1}}
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_BYTE-1:0]        i_rx_data,
    input  logic                      i_rx_done,
    output logic                      o_wr_enable,
    output logic [NB_PC-1:0]          o_wr_addr,
    output logic [NB_INSTRUCTION-1:0] o_wr_data,
    output logic                      o_pc_hold,
    output logic                      o_load_done,
    output logic                      o_error,
    output logic [NB_PC-1:0]          o_word_count,
    output logic [NB_BYTE-1:0]        o_checksum
);

    localparam int unsigned BYTES_PER_WORD = NB_INSTRUCTION / NB_BYTE;
    localparam int unsigned NB_BIDX        = $clog2(BYTES_PER_WORD);
    // The buffer holds the first BYTES_PER_WORD-1 bytes; the last byte is taken straight from the input.
    localparam int unsigned NB_BUF         = NB_INSTRUCTION - NB_BYTE;
    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BYTES_PER_WORD - 1);
    localparam logic [NB_PC-1:0]   ADDR_STEP = NB_PC'(NB_INSTRUCTION / 8);
    localparam logic [NB_PC-1:0]   LAST_WORD = NB_PC'(MEM_DEPTH - 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t                      state_q, state_d;
    logic [NB_BIDX-1:0]          byte_idx_q, byte_idx_d;
    logic [NB_BUF-1:0]           word_q, word_d;
    logic [NB_PC-1:0]            addr_q, addr_d;
    logic [NB_PC-1:0]            count_q, count_d;
    logic                        error_q, error_d;
    logic                        wr_enable_q, wr_enable_d;
    logic [NB_INSTRUCTION-1:0]   wr_data_q, wr_data_d;
    logic                        pc_hold_q, pc_hold_d;
    logic                        load_done_q, load_done_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]          checksum_q, checksum_d;
`endif

    // State and datapath registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
            wr_enable_q <= 1'b0;
            wr_data_q   <= '0;
            pc_hold_q   <= 1'b1;
            load_done_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            error_q     <= error_d;
            wr_enable_q <= wr_enable_d;
            wr_data_q   <= wr_data_d;
            pc_hold_q   <= pc_hold_d;
            load_done_q <= load_done_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // Next-state, byte assembly and registered output values
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        count_d     = count_q;
        error_d     = error_q;
        wr_enable_d = 1'b0;
        wr_data_d   = wr_data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    addr_d     = '0;
                    count_d    = '0;
                    error_d    = 1'b0;
                    byte_idx_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    state_d    = RECV;
                end
            end

            RECV: begin
                if (i_rx_done) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q ^ i_rx_data;
`endif
                    word_d     = {word_q[NB_BUF-NB_BYTE-1:0], i_rx_data};
                    byte_idx_d = NB_BIDX'(byte_idx_q + 1'b1);
                    if (byte_idx_q == LAST_BYTE) begin
                        wr_enable_d = 1'b1;
                        wr_data_d   = {word_q, i_rx_data};
                        byte_idx_d  = '0;
                        state_d     = WRITE;
                    end
                end
            end

            WRITE: begin
                count_d = count_q + NB_PC'(1);
                if (wr_data_q == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    // A byte arriving during the HALT write is the checksum byte.
                    if (i_rx_done) begin
                        error_d = (i_rx_data != checksum_q);
                        state_d = DONE;
                    end else begin
                        state_d = CHECK;
                    end
`else
                    state_d = DONE;
`endif
                end else if (count_q == LAST_WORD) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = RECV;
                    // A byte arriving during the write becomes byte 0 of the next word.
                    if (i_rx_done) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        checksum_d = checksum_q ^ i_rx_data;
`endif
                        word_d     = {word_q[NB_BUF-NB_BYTE-1:0], i_rx_data};
                        byte_idx_d = NB_BIDX'(1);
                    end
                end
            end

`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK: begin
                if (i_rx_done) begin
                    error_d = (i_rx_data != checksum_q);
                    state_d = DONE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase

        load_done_d = (state_d == DONE);
        pc_hold_d   = !((state_d == DONE) && !error_d);
    end

    assign o_wr_enable  = wr_enable_q;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_pc_hold    = pc_hold_q;
    assign o_load_done  = load_done_q;
    assign o_error      = error_q;
    assign o_word_count = count_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign o_checksum   = checksum_q;
`else
    assign o_checksum   = '0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: the stimulus pushes expected memory writes,
// and a negedge monitor pops them and compares each write the DUT presents.
module tb_instruction_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        pc_hold;
    logic        load_done;
    logic        error;
    logic [31:0] word_count;
    logic [7:0]  checksum;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    logic [7:0]  stream[$];
    int          errors = 0;
    int          checks = 0;

    instruction_loader #(
        .NB_PC(32), .NB_INSTRUCTION(32), .NB_BYTE(8), .MEM_DEPTH(DEPTH), .HALT_WORD(HALT)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_wr_enable(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_pc_hold(pc_hold), .o_load_done(load_done), .o_error(error),
        .o_word_count(word_count), .o_checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends the stream queue, one strobe per byte, with 0..gmax idle cycles between bytes
    task automatic send_stream(input int gmax);
        foreach (stream[i]) begin
            rx_data = stream[i];
            rx_done = 1'b1;
            @(posedge clk); #1;
            rx_done = 1'b0;
            repeat ($urandom_range(gmax, 0)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_reset_values();
        chk("rst_wr_enable", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_pc_hold", 32'(pc_hold), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
    endtask

    task automatic check_status(input int n, input bit err, input logic [7:0] cs);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (load_done) break;
        end
        chk("load_done", 32'(load_done), 32'd1);
        chk("word_count", word_count, 32'(n));
        chk("error", 32'(error), 32'(err));
        chk("pc_hold", 32'(pc_hold), 32'(err));
        chk("checksum", 32'(checksum), 32'(cs));
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Reference model: walk the program word by word, predict writes and the final status, then drive it.
    // cs_sel: -1 random checksum byte, -2 correct checksum byte, >=0 that literal byte.
    task automatic run_load(input int gmax, input int cs_sel, input bit coincide);
        int         n;
        int         last;
        bit         err;
        bit         halted;
        logic [7:0] cs;
        logic [7:0] csb;
        wr_t        e;
        n = 0; err = 1'b1; halted = 1'b0; cs = 8'h00;
        last = prog.size() - 1;
        for (int i = 0; i < prog.size(); i++) begin
            if (n == DEPTH) break;
            e.addr = 32'(n * 4);
            e.data = prog[i];
            exp_q.push_back(e);
            n++;
            cs = cs ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
            if (prog[i] == HALT) begin
                halted = 1'b1;
                err = 1'b0;
                last = i;
                break;
            end
        end
        stream.delete();
        for (int i = 0; i <= last; i++)
            for (int k = 3; k >= 0; k--)
                stream.push_back(prog[i][8*k +: 8]);
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (halted) begin
            if (cs_sel == -2)     csb = cs;
            else if (cs_sel >= 0) csb = 8'(cs_sel);
            else                  csb = ($urandom_range(1, 0) != 0) ? cs : (cs ^ 8'($urandom_range(255, 1)));
            stream.push_back(csb);
            err = (csb != cs);
        end
`else
        cs = 8'h00;
        csb = 8'(cs_sel);
        if (halted && csb == 8'h00) csb = 8'h01;
`endif
        // Trailing bytes after the load has ended must be ignored.
        repeat (3) stream.push_back(8'($urandom));
        if (coincide) begin
            // The start is taken together with a byte strobe; that byte must be dropped.
            rx_data = 8'h5A;
            rx_done = 1'b1;
            pulse_start();
            rx_done = 1'b0;
        end else begin
            pulse_start();
        end
        send_stream(gmax);
        check_status(n, err, cs);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
        #12;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bytes before any start: no writes, still idle
        stream.delete();
        repeat (6) stream.push_back(8'($urandom));
        send_stream(1);
        @(negedge clk);
        chk("idle_load_done", 32'(load_done), 32'd0);
        chk("idle_word_count", word_count, 32'd0);
        chk("idle_pc_hold", 32'(pc_hold), 32'd1);
        @(posedge clk); #1;

        // Basic program followed by HALT
        prog = '{32'h20080005, HALT};
        run_load(2, -2, 1'b0);

        // Back-to-back strobes, including one in each write cycle
        prog = '{32'h00000001, 32'h00000002, HALT};
        run_load(0, -2, 1'b0);

        // Memory fills without HALT: overflow error
        prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_load(1, -1, 1'b0);

        // Start coincident with a byte strobe in DONE
        prog = '{32'h11223344, HALT};
        run_load(1, -2, 1'b1);

        // Reset in the middle of a word
        pulse_start();
        stream = '{8'h8C, 8'h01};
        send_stream(0);
        rst_n = 1'b0;
        #2;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;
        prog = '{32'h8C010000, HALT};
        run_load(1, -2, 1'b0);

        // Checksum byte right and wrong (literal only matters with the checksum option)
        prog = '{32'h12345678, HALT};
        run_load(1, 8'h08, 1'b0);
        prog = '{32'h12345678, HALT};
        run_load(1, 8'h09, 1'b0);

        // Randomized programs
        for (int it = 0; it < 30; it++) begin
            int len;
            logic [31:0] w;
            prog.delete();
            len = $urandom_range(6, 1);
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
                prog.push_back(w);
            end
            if (!(len >= DEPTH && $urandom_range(2, 0) == 0))
                prog[$urandom_range(len - 1, 0)] = HALT;
            run_load($urandom_range(3, 0), -1, ($urandom_range(3, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
